// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding and pointer helpers for the RAM access controller.
`default_nettype none

package ram_ctrl_pkg;

    localparam int PTR_BYTES = 2;
    localparam int PTR_ARG_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PTR_LO = 3'd1,
        PTR_HI = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Assembles a little-endian pointer {hi,lo}; the caller truncates or extends to its address width.
    function automatic logic [2*PTR_ARG_W-1:0] make_ptr(
        input logic [PTR_ARG_W-1:0] hi,
        input logic [PTR_ARG_W-1:0] lo,
        input int unsigned          width
    );
        return ({{PTR_ARG_W{1'b0}}, hi} << width) | {{PTR_ARG_W{1'b0}}, lo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-request controller for a synchronous single-port RAM,
// performing direct or pointer-indirect byte accesses.
`default_nettype none

module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_indirect,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_eaddr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_t                state;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] ptr_lo;
    logic                  drive_en;
    logic [ADDR_WIDTH-1:0] ptr_eaddr;

    assign req_ready = (state == IDLE) && !rst;
    assign ram_data  = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

    // High byte arrives on the bus during PTR_HI; combine with the captured low byte.
    assign ptr_eaddr = ADDR_WIDTH'(make_ptr(PTR_ARG_W'(ram_data), PTR_ARG_W'(ptr_lo), DATA_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ptr_lo    <= '0;
            drive_en  <= 1'b0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_eaddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        ram_addr <= req_addr;
                        ram_cs   <= 1'b1;
                        if (req_indirect) begin
                            // Pointer fetches are always reads.
                            ram_we <= 1'b0;
                            ram_oe <= 1'b1;
                            state  <= PTR_LO;
                        end else begin
                            ram_we   <= req_we;
                            ram_oe   <= !req_we;
                            drive_en <= req_we;
                            state    <= ACCESS;
                        end
                    end
                end
                PTR_LO: begin
                    ptr_lo   <= ram_data;
                    ram_addr <= ram_addr + ADDR_WIDTH'(1);
                    state    <= PTR_HI;
                end
                PTR_HI: begin
                    ram_addr <= ptr_eaddr;
                    ram_we   <= we_q;
                    ram_oe   <= !we_q;
                    drive_en <= we_q;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata <= ram_data;
                    end
                    rsp_eaddr <= ram_addr;
                    rsp_valid <= 1'b1;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_oe    <= 1'b0;
                    drive_en  <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_oe    <= 1'b0;
                    drive_en  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request-side controller that sits directly upstream of the single-port synchronous RAM and owns its `addr`/`data`/`cs`/`we`/`oe` pins. It accepts one request at a time from the datapath over a valid/ready handshake and performs either a direct byte access or an indirect access. An indirect access first fetches a two-byte little-endian pointer from RAM, then accesses the byte it points to. Pointer resolution lives entirely here; the RAM only ever sees a final effective address.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: RAM address width.
- `DATA_WIDTH`, 8: RAM data width.

Ports:
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller idle; transfer occurs when both are high at posedge.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_indirect`  in  1: 1 = `req_addr` holds a pointer location.
- `req_addr`  in  ADDR_WIDTH: direct address, or pointer location.
- `req_wdata`  in  DATA_WIDTH: write byte.
- `rsp_valid`  out  1: one-cycle completion pulse (reads and writes).
- `rsp_rdata`  out  DATA_WIDTH: read byte; holds until next read completes.
- `rsp_eaddr`  out  ADDR_WIDTH: effective address used by the completed access.
- `ram_addr`  out  ADDR_WIDTH: RAM address.
- `ram_data`  inout  DATA_WIDTH: RAM data bus.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each: RAM controls.

## Operation
- States: IDLE, PTR_LO, PTR_HI, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch `req_*`.
  - Go to PTR_LO if `req_indirect`, else to ACCESS with effective address = `req_addr`.
- PTR_LO:
  - Read cycle at pointer location P.
  - Next state PTR_HI; the low byte is captured at the exit edge.
- PTR_HI:
  - Read cycle at (P+1) mod 2^ADDR_WIDTH; the pointer wraps from 0xFFF to 0x000.
  - Next state ACCESS; the high byte is captured at the exit edge.
  - Effective address = {hi,lo} truncated, or zero-extended, to ADDR_WIDTH. For 12/8 that is {hi[3:0],lo}.
- ACCESS:
  - Read: `ram_cs`=1, `ram_oe`=1, `ram_we`=0. The controller captures `ram_data` into `rsp_rdata` at the exit edge.
  - Write: `ram_cs`=1, `ram_we`=1, `ram_oe`=0, `ram_data` driven with the latched wdata. The RAM commits at the exit edge.
  - Next state RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_eaddr` valid.
  - Next state IDLE.
- Outside ACCESS-write, the controller drives `ram_data` to Z.
- Outside PTR_LO/PTR_HI/ACCESS, `ram_cs`, `ram_we` and `ram_oe` are 0 and `ram_addr` holds its last value.
- Indirect pointer fetches are always reads, regardless of `req_we`.
- No response backpressure: the consumer must accept the `rsp_valid` pulse.
- `req_valid` outside IDLE is ignored; the request must be held until its handshake.

## Timing
- RAM control outputs decode from registered state with no input-to-output combinational path.
- `req_ready` is combinational from state and forced to 0 while `rst` is high.
- Read data is valid on `ram_data` after the RAM's internal negedge update and is sampled at the next posedge.
- Latency, counted from the handshake edge E, with `rsp_valid` high in the cycle after edge E+n:
  - Direct read or write: n=1. `rsp_valid` is high in cycle E+1..E+2; `req_ready` is high again from E+2.
  - Indirect read or write: n=3. `rsp_valid` is high in cycle E+3..E+4.
- Back-to-back throughput:
  - One direct access per 3 cycles.
  - One indirect access per 5 cycles.
- Reset values:
  - state = IDLE.
  - `ram_cs`, `ram_we`, `ram_oe` = 0; `ram_data` = Z; `ram_addr` = 0.
  - `rsp_valid` = 0; `rsp_rdata` = 0; `rsp_eaddr` = 0.
- Reset mid-operation aborts the access immediately, asynchronously.
  - `ram_cs`/`ram_we` drop before the next edge, so no RAM write commits after `rst` rises.
  - No `rsp_valid` is produced for the aborted request.

## Structure
- Shared package `ram_ctrl_pkg`:
  - state enum (IDLE, PTR_LO, PTR_HI, ACCESS, RESP).
  - localparam `PTR_BYTES`=2.
  - pointer-assembly function `make_ptr(hi, lo)`, parameterized by width.
- No sub-module: the FSM, request latch, pointer register and tristate driver stay flat in `ram_access_ctrl`.

## Test plan
All scenarios use ADDR_WIDTH=12, DATA_WIDTH=8, with the controller connected to a RAM model.
- **Direct write then read:** write 0x5A to 0x123, then read 0x123.
  - `rsp_rdata`=0x5A, `rsp_eaddr`=0x123.
  - Each `rsp_valid` arrives exactly 1 cycle after its handshake edge.
- **Indirect read:** mem[0x040]=0x34, mem[0x041]=0x82, mem[0x234]=0xC7; indirect read at 0x040.
  - `rsp_eaddr`=0x234 (the high nibble 8 is dropped) and `rsp_rdata`=0xC7.
  - Latency is 3 cycles.
- **Indirect write with pointer wrap:** mem[0xFFF]=0x10, mem[0x000]=0x00; indirect write of 0x99 at 0xFFF.
  - mem[0x010]=0x99, `rsp_eaddr`=0x010.
  - mem[0xFFF] and mem[0x000] are unchanged.
- **Back-to-back with `req_valid` held high:** 4 direct reads.
  - Handshakes occur exactly every 3 cycles; `req_ready`=0 during ACCESS/RESP.
  - `ram_data` is never driven by the controller during a read.
- **Reset during a write:** assert `rst` mid-ACCESS of a write of 0xEE to 0x300.
  - `ram_cs`=0 before the next edge; mem[0x300] keeps its prior value.
  - No `rsp_valid`; all outputs hold their reset values.
- **Bus discipline:** random mix of direct and indirect requests.
  - `ram_data` is never driven by the controller while `ram_oe`=1, and `ram_we` and `ram_oe` are never both 1.
  - Every response matches a reference memory model.
